// File: rtl/stopwatch_upcnt.sv
// stopwatch_upcnt: four-digit BCD stopwatch with prescaler, lap display and
// a three-state control FSM (IDLE / RUNNING / PAUSED).
//
// Build option: define STOPWATCH_SAT_EN to make the count saturate at 9999
// (no wrap, no CO, FSM drops to PAUSED). Default build wraps 9999 -> 0000
// and pulses CO for one cycle.
//
// Input qualification: EN is a plain per-cycle strobe with no back-pressure;
// it is consumed on every rising CLOCK edge where it is high and the FSM is
// RUNNING, and dropped otherwise. START/STOP/CLR/LAP are levels sampled on
// every edge, resolved in priority CLR > STOP > START > LAP.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 RUNNING, 2 PAUSED) so that
// checkers can distinguish IDLE from PAUSED, which RUN alone cannot.

module stopwatch_upcnt #(
  parameter int DIV = 10
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        EN,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLR,
  input  logic        LAP,
  output logic [15:0] CNT,
  output logic [15:0] DISP,
  output logic        RUN,
  output logic        CO,
  output logic        LAPV,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_t;

  // Terminal prescaler value; with DIV=1 every qualified EN increments.
  localparam logic [3:0] PRE_LAST = 4'(DIV - 1);

  state_t      state;
  state_t      state_nxt;

  logic [15:0] cnt;
  logic [15:0] lap_reg;
  logic [3:0]  pre;
  logic        co;
  logic        lapv;
  logic        lap_q;

  logic        lap_rise;
  logic        cmd_lap;
  logic        en_run;
  logic        tick;
  logic        at_max;

  // One decimal step with ripple carry through all four digits in one cycle.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // LAP acts only on a rising edge and only when no higher-priority command
  // is present in the same cycle.
  assign lap_rise = LAP & ~lap_q;
  assign cmd_lap  = lap_rise & ~CLR & ~STOP & ~START;

  // EN is only meaningful while RUNNING; tick marks a prescaler roll-over.
  assign en_run = (state == S_RUNNING) & EN;
  assign tick   = en_run & (pre == PRE_LAST);
  assign at_max = (cnt == 16'h9999);

  // FSM state register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic: CLR beats STOP beats START.
  always_comb begin
    state_nxt = state;
    if (CLR) begin
      state_nxt = S_IDLE;
    end else if (STOP) begin
      if (state == S_RUNNING) begin
        state_nxt = S_PAUSED;
      end
    end else if (START) begin
      if (state != S_RUNNING) begin
        state_nxt = S_RUNNING;
      end
    end
`ifdef STOPWATCH_SAT_EN
    // An increment attempted at 9999 parks the stopwatch.
    if (!CLR && tick && at_max) begin
      state_nxt = S_PAUSED;
    end
`endif
  end

  // FSM and datapath outputs; DISP selection is purely combinational.
  always_comb begin
    RUN       = (state == S_RUNNING);
    dbg_state = state;
    CNT       = cnt;
    CO        = co;
    LAPV      = lapv;
    DISP      = lapv ? lap_reg : cnt;
  end

  // Prescaler and BCD count; CLR clears both and wins over any increment.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pre <= 4'd0;
      cnt <= 16'h0000;
    end else if (CLR) begin
      pre <= 4'd0;
      cnt <= 16'h0000;
    end else if (en_run) begin
      if (pre == PRE_LAST) begin
        pre <= 4'd0;
`ifdef STOPWATCH_SAT_EN
        if (!at_max) begin
          cnt <= bcd_inc(cnt);
        end
`else
        cnt <= bcd_inc(cnt);
`endif
      end else begin
        pre <= pre + 4'd1;
      end
    end
  end

  // Carry-out pulse for the cycle after a 9999 -> 0000 wrap.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      co <= 1'b0;
    end else begin
`ifdef STOPWATCH_SAT_EN
      co <= 1'b0;
`else
      co <= tick & at_max & ~CLR;
`endif
    end
  end

  // LAP edge history, lap register and lap-valid flag.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      lap_q   <= 1'b0;
      lap_reg <= 16'h0000;
      lapv    <= 1'b0;
    end else begin
      lap_q <= LAP;
      if (CLR) begin
        lapv <= 1'b0;
      end else if (cmd_lap) begin
        if (lapv) begin
          lapv <= 1'b0;
        end else if (state == S_RUNNING) begin
          lap_reg <= cnt;
          lapv    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_upcnt.sv
// Testbench for stopwatch_upcnt. Two instances share all inputs: u10 uses
// DIV=10 for prescaler/lap/reset scenarios, u1 uses DIV=1 so the count can
// be driven to 9999 in a reasonable number of cycles. The driver pushes a
// hand-computed expected vector (tagged with the instance to look at) after
// each checkpoint; the monitor pops and compares on the falling edge.

module tb_stopwatch_upcnt;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam int         W        = 37;

  logic        CLOCK;
  logic        RESET;
  logic        EN;
  logic        START;
  logic        STOP;
  logic        CLR;
  logic        LAP;

  logic [15:0] cnt0, disp0, cnt1, disp1;
  logic        run0, co0, lapv0, run1, co1, lapv1;
  logic [1:0]  st0, st1;

  logic [W:0]   exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  stopwatch_upcnt #(.DIV(10)) u10 (
    .CLOCK(CLOCK), .RESET(RESET), .EN(EN), .START(START), .STOP(STOP),
    .CLR(CLR), .LAP(LAP), .CNT(cnt0), .DISP(disp0), .RUN(run0), .CO(co0),
    .LAPV(lapv0), .dbg_state(st0)
  );

  stopwatch_upcnt #(.DIV(1)) u1 (
    .CLOCK(CLOCK), .RESET(RESET), .EN(EN), .START(START), .STOP(STOP),
    .CLR(CLR), .LAP(LAP), .CNT(cnt1), .DISP(disp1), .RUN(run1), .CO(co1),
    .LAPV(lapv1), .dbg_state(st1)
  );

  // Clock and watchdog
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step(input logic en, input logic st, input logic sp,
                      input logic cl, input logic lp);
    EN = en; START = st; STOP = sp; CLR = cl; LAP = lp;
    @(posedge CLOCK);
    #1;
    EN = 1'b0; START = 1'b0; STOP = 1'b0; CLR = 1'b0; LAP = 1'b0;
  endtask

  task automatic ens(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input logic sel, input logic [15:0] c, input logic [15:0] d,
                     input logic r, input logic co, input logic lv,
                     input logic [1:0] s, input string nm);
    exp_q.push_back({sel, c, d, r, co, lv, s});
    name_q.push_back(nm);
  endtask

  // Scoreboard monitor
  always @(negedge CLOCK) begin
    logic [W:0]   e;
    logic [W-1:0] act;
    string        nm;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = e[W] ? {cnt1, disp1, run1, co1, lapv1, st1}
                 : {cnt0, disp0, run0, co0, lapv0, st0};
      n_vec++;
      if (act != e[W-1:0]) begin
        n_err++;
        $display("FAIL %s (u%0d): got cnt=%h disp=%h run=%b co=%b lapv=%b st=%0d, expected cnt=%h disp=%h run=%b co=%b lapv=%b st=%0d",
                 nm, e[W] ? 1 : 10,
                 act[36:21], act[20:5], act[4], act[3], act[2], act[1:0],
                 e[36:21], e[20:5], e[4], e[3], e[2], e[1:0]);
      end
    end
  end

  // Stimulus
  initial begin
    RESET = 1'b1;
    EN = 1'b0; START = 1'b0; STOP = 1'b0; CLR = 1'b0; LAP = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    chk(0, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "reset_state");
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;

    // EN in IDLE does nothing
    ens(12);
    chk(0, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "idle_en_ignored");

    // START, 25 EN -> 0002 with 5 pending prescale
    step(0, 1, 0, 0, 0);
    chk(0, 16'h0000, 16'h0000, 1, 0, 0, ST_RUN, "start");
    ens(25);
    chk(0, 16'h0002, 16'h0002, 1, 0, 0, ST_RUN, "run_25en");
    ens(4);
    chk(0, 16'h0002, 16'h0002, 1, 0, 0, ST_RUN, "prescale_29en");
    ens(1);
    chk(0, 16'h0003, 16'h0003, 1, 0, 0, ST_RUN, "prescale_30en");

    // Lap at 0042, keep counting to 0050, release
    ens(390);
    chk(0, 16'h0042, 16'h0042, 1, 0, 0, ST_RUN, "count_0042");
    step(0, 0, 0, 0, 1);
    chk(0, 16'h0042, 16'h0042, 1, 0, 1, ST_RUN, "lap_latch");
    ens(80);
    chk(0, 16'h0050, 16'h0042, 1, 0, 1, ST_RUN, "lap_frozen");
    step(0, 0, 0, 0, 1);
    chk(0, 16'h0050, 16'h0050, 1, 0, 0, ST_RUN, "lap_release");

    // Partial prescale survives a pause
    ens(3);
    step(0, 0, 1, 0, 0);
    chk(0, 16'h0050, 16'h0050, 0, 0, 0, ST_PAUSE, "stop");
    ens(3);
    chk(0, 16'h0050, 16'h0050, 0, 0, 0, ST_PAUSE, "paused_en_ignored");
    step(0, 1, 1, 0, 0);
    chk(0, 16'h0050, 16'h0050, 0, 0, 0, ST_PAUSE, "start_stop_same");
    step(0, 1, 0, 0, 0);
    chk(0, 16'h0050, 16'h0050, 1, 0, 0, ST_RUN, "resume");
    ens(6);
    chk(0, 16'h0050, 16'h0050, 1, 0, 0, ST_RUN, "resume_9of10");
    ens(1);
    chk(0, 16'h0051, 16'h0051, 1, 0, 0, ST_RUN, "resume_10of10");
    step(0, 0, 0, 0, 1);
    chk(0, 16'h0051, 16'h0051, 1, 0, 1, ST_RUN, "lap_latch2");
    step(0, 1, 0, 1, 0);
    chk(0, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "clr_start");

    // DIV=1 instance: BCD ripple 0999 -> 1000, then 9999 boundary
    step(0, 1, 0, 0, 0);
    ens(999);
    chk(1, 16'h0999, 16'h0999, 1, 0, 0, ST_RUN, "count_0999");
    ens(1);
    chk(1, 16'h1000, 16'h1000, 1, 0, 0, ST_RUN, "ripple_1000");
    ens(8999);
    chk(1, 16'h9999, 16'h9999, 1, 0, 0, ST_RUN, "count_9999");
    ens(1);
`ifdef STOPWATCH_SAT_EN
    chk(1, 16'h9999, 16'h9999, 0, 0, 0, ST_PAUSE, "sat_hold");
    step(0, 0, 0, 0, 0);
    chk(1, 16'h9999, 16'h9999, 0, 0, 0, ST_PAUSE, "sat_hold_next");
`else
    chk(1, 16'h0000, 16'h0000, 1, 1, 0, ST_RUN, "wrap_co");
    step(0, 0, 0, 0, 0);
    chk(1, 16'h0000, 16'h0000, 1, 0, 0, ST_RUN, "wrap_co_drop");
`endif

    // CLR coinciding with the 9999 increment
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    ens(9999);
    chk(1, 16'h9999, 16'h9999, 1, 0, 0, ST_RUN, "count_9999_again");
    step(1, 0, 0, 1, 0);
    chk(1, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "clr_beats_wrap");
    step(0, 0, 0, 0, 0);
    chk(1, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "clr_wrap_no_co");

    // Async reset mid-run at 0317 with lap shown and prescaler at 3
    step(0, 1, 0, 0, 0);
    ens(3173);
    chk(0, 16'h0317, 16'h0317, 1, 0, 0, ST_RUN, "count_0317");
    step(0, 0, 0, 0, 1);
    chk(0, 16'h0317, 16'h0317, 1, 0, 1, ST_RUN, "lap_0317");
    step(0, 0, 0, 0, 0);
    RESET = 1'b1;
    #1;
    chk(0, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "async_reset");
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    ens(15);
    chk(0, 16'h0000, 16'h0000, 0, 0, 0, ST_IDLE, "post_reset_en_ignored");
    step(0, 1, 0, 0, 0);
    ens(7);
    chk(0, 16'h0000, 16'h0000, 1, 0, 0, ST_RUN, "post_reset_prescale_7");
    ens(3);
    chk(0, 16'h0001, 16'h0001, 1, 0, 0, ST_RUN, "post_reset_prescale_10");

    // Drain the scoreboard, bounded
    repeat (3) @(negedge CLOCK);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_upcnt.md
STOPWATCH_UPCNT -- requirements
Module: stopwatch_upcnt

Interface
REQ-001 Parameter DIV, default 10, is the number of EN pulses per count increment; legal range 1..15.
REQ-002 CLOCK  input  1  rising-edge system clock.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 EN  input  1  single-cycle tick from an external prescaler; may be high on consecutive cycles.
REQ-005 START  input  1  level, sampled each CLOCK; requests counting.
REQ-006 STOP  input  1  level, sampled each CLOCK; requests pause.
REQ-007 CLR  input  1  level, sampled each CLOCK; clears the count.
REQ-008 LAP  input  1  level, sampled each CLOCK; freezes or releases the display.
REQ-009 CNT  output  16  live count, four BCD digits, [15:12] most significant.
REQ-010 DISP  output  16  displayed value, either live CNT or the latched lap value.
REQ-011 RUN  output  1  high while the FSM is in RUNNING.
REQ-012 CO  output  1  one-cycle pulse on the 9999 -> 0000 transition.
REQ-013 LAPV  output  1  high while DISP shows the latched lap value.

Function
REQ-014 FSM states are IDLE, RUNNING and PAUSED; RESET enters IDLE.
REQ-015 Priority each cycle is CLR > STOP > START > LAP.
REQ-016 CLR from any state: next state IDLE, CNT=0000, prescaler=0, LAPV=0.
REQ-017 START in IDLE or PAUSED: next state RUNNING; START in RUNNING has no effect.
REQ-018 STOP in RUNNING: next state PAUSED; STOP in IDLE or PAUSED has no effect.
REQ-019 START and STOP asserted in the same cycle: STOP wins and START is ignored.
REQ-020 Prescaler: while RUNNING, each EN cycle increments the prescaler; when the prescaler reaches DIV-1 it returns to 0 and CNT increments on the same edge.
REQ-021 When not RUNNING, EN is ignored and the prescaler holds its value; PAUSED then START resumes the same partial prescale.
REQ-022 Increment is decimal with ripple carry: a digit at 9 goes to 0 and carries into the next digit within the same cycle, so CNT is never non-BCD.
REQ-023 Wrap: 9999 plus one gives 0000, and CO is high for exactly the cycle after that edge; RUN stays high.
REQ-024 A CLR in the same cycle as a 9999 increment wins: CNT=0000 and CO stays low.
REQ-025 LAP rising edge (edge-detected internally) while RUNNING and LAPV=0: latch CNT into the lap register and set LAPV=1.
REQ-026 LAP rising edge while LAPV=1, in any state: clear LAPV.
REQ-027 DISP equals the lap register when LAPV=1, otherwise CNT; the selection is combinational.
REQ-028 Latency: CNT changes on the CLOCK edge that samples the qualifying EN; RUN changes on the edge that samples START or STOP.

Reset
REQ-029 RESET asserted sets state IDLE, CNT=0000, lap register=0000, prescaler=0, CO=0, LAPV=0, RUN=0, and clears the LAP edge-detector history, all without waiting for CLOCK.
REQ-030 RESET asserted mid-count discards all state; after release the block waits in IDLE for START.

Configuration
REQ-031 With macro STOPWATCH_SAT_EN defined, CNT saturates at 9999: further increments hold 9999, CO never pulses, and the FSM moves to PAUSED on the increment attempted at 9999.
REQ-032 With STOPWATCH_SAT_EN undefined, the wrap behaviour of REQ-023 applies.

Verification
REQ-033 RESET, then START, then 25 EN pulses with DIV=10 -> CNT=0002, RUN=1, prescaler at 5 (the 5 remaining EN pulses give CNT=0003).
REQ-034 Preload to 0999 via a run, then one increment -> CNT=1000 in a single cycle with no intermediate non-BCD value.
REQ-035 CNT=9999 with DIV=1 and one EN -> CNT=0000 and CO high for 1 cycle; with STOPWATCH_SAT_EN defined -> CNT=9999, CO=0, RUN=0.
REQ-036 START and STOP in the same cycle from PAUSED -> stays PAUSED; CLR+START in RUNNING -> IDLE, CNT=0000.
REQ-037 LAP pulse at CNT=0042, continue to 0050 -> DISP=0042, LAPV=1; second LAP -> DISP=0050, LAPV=0.
REQ-038 RESET pulsed asynchronously mid-run at CNT=0317 -> all outputs 0 immediately; EN pulses ignored until START.
